// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one clocked ALU between two requesters
// ports: clk/rst (async, active-high); hold freezes new grants
//   reqN_valid/ready/a/b/op : operand packets in; rspN_valid : result pulses out
//   rsp_result/rsp_carry : ALU output passthrough; alu_a/b/op/en : registered ALU inputs
//   alu_result/alu_carry : from ALU; busy : something issued or in flight
module alu_share_arbiter #(
  parameter int DW = 4,
  parameter int OPW = 3,
  parameter int ALU_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           hold,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic [OPW-1:0] req0_op,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  input  logic [OPW-1:0] req1_op,
  output logic           rsp0_valid,
  output logic           rsp1_valid,
  output logic [DW-1:0]  rsp_result,
  output logic           rsp_carry,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_op,
  output logic           alu_en,
  input  logic [DW-1:0]  alu_result,
  input  logic           alu_carry,
  output logic           busy
);
  logic               last, iid, g0, g1;
  logic [ALU_LAT-1:0] tv, tid;
  // last holds the id of the most recent grant; a tie goes to the other requester
  always_comb begin
    g0 = !rst && !hold && req0_valid && (!req1_valid || last);
    g1 = !rst && !hold && req1_valid && (!req0_valid || !last);
  end
  assign req0_ready = g0;
  assign req1_ready = g1;
  // iid tags the op currently on the ALU bus; tv/tid follow it through the ALU pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      alu_en <= 1'b0;
      last   <= 1'b1;
      iid    <= 1'b0;
      tv     <= '0;
      tid    <= '0;
    end else begin
      alu_en <= g0 || g1;
      tv[0]  <= alu_en;
      tid[0] <= iid;
      for (int i = 1; i < ALU_LAT; i++) begin
        tv[i]  <= tv[i-1];
        tid[i] <= tid[i-1];
      end
      if (g0 || g1) begin
        alu_a  <= g1 ? req1_a : req0_a;
        alu_b  <= g1 ? req1_b : req0_b;
        alu_op <= g1 ? req1_op : req0_op;
        last   <= g1;
        iid    <= g1;
      end
    end
  end
  assign rsp0_valid = tv[ALU_LAT-1] && !tid[ALU_LAT-1];
  assign rsp1_valid = tv[ALU_LAT-1] && tid[ALU_LAT-1];
  assign rsp_result = alu_result;
  assign rsp_carry  = alu_carry;
  assign busy       = alu_en || |tv;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: table-driven check of the arbiter at ALU_LAT=1 plus a ALU_LAT=3 pipeline sequence
module tb_alu_share_arbiter;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  function automatic logic [4:0] f(logic [3:0] a, logic [3:0] b, logic [2:0] op);
    case (op)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: return {1'b0, a} - {1'b0, b};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      3'd5: return {1'b0, ~a};
      3'd6: return {1'b0, a & ~b};
      default: return {a, 1'b0};
    endcase
  endfunction
  function automatic logic [10:0] pk(logic [3:0] a, logic [3:0] b, logic [2:0] op);
    return {a, b, op};
  endfunction
  logic hold = 0, v0 = 0, v1 = 0, r0, r1, rv0, rv1, en, busy, carry, ac;
  logic [3:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0, aa, ab, res, ar;
  logic [2:0] op0 = 0, op1 = 0, aop;
  logic [4:0] p1 = 0;
  alu_share_arbiter #(.DW(4), .OPW(3), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req0_valid(v0), .req0_ready(r0), .req0_a(a0), .req0_b(b0), .req0_op(op0),
    .req1_valid(v1), .req1_ready(r1), .req1_a(a1), .req1_b(b1), .req1_op(op1),
    .rsp0_valid(rv0), .rsp1_valid(rv1), .rsp_result(res), .rsp_carry(carry),
    .alu_a(aa), .alu_b(ab), .alu_op(aop), .alu_en(en),
    .alu_result(ar), .alu_carry(ac), .busy(busy)
  );
  always @(posedge clk) p1 <= f(aa, ab, aop);
  assign {ac, ar} = p1;
  logic v03 = 0, v13 = 0, r03, r13, rv03, rv13, en3, busy3, carry3, ac3;
  logic [3:0] a03 = 0, b03 = 0, a13 = 0, b13 = 0, aa3, ab3, res3, ar3;
  logic [2:0] op03 = 0, op13 = 0, aop3;
  logic [4:0] q [3] = '{5'd0, 5'd0, 5'd0};
  alu_share_arbiter #(.DW(4), .OPW(3), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .hold(1'b0),
    .req0_valid(v03), .req0_ready(r03), .req0_a(a03), .req0_b(b03), .req0_op(op03),
    .req1_valid(v13), .req1_ready(r13), .req1_a(a13), .req1_b(b13), .req1_op(op13),
    .rsp0_valid(rv03), .rsp1_valid(rv13), .rsp_result(res3), .rsp_carry(carry3),
    .alu_a(aa3), .alu_b(ab3), .alu_op(aop3), .alu_en(en3),
    .alu_result(ar3), .alu_carry(ac3), .busy(busy3)
  );
  always @(posedge clk) begin
    q[0] <= f(aa3, ab3, aop3);
    q[1] <= q[0];
    q[2] <= q[1];
  end
  assign {ac3, ar3} = q[2];
  typedef struct {
    logic rst, hold, v0;
    logic [10:0] s0;
    logic v1;
    logic [10:0] s1;
    logic r0, r1, en, rv0, rv1, busy;
    logic [10:0] bus;
    logic [4:0] d;
  } vec_t;
  vec_t tv [$];
  int total = 0, bad = 0;
  task automatic chk(string n, logic [15:0] got, logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask
  localparam logic [10:0] Z = 11'd0;
  initial begin
    // reset, then single req0 op: bus in next cycle, rsp0 one cycle later
    tv.push_back('{1, 0, 0, Z, 0, Z, 0, 0, 0, 0, 0, 0, Z, 5'd0});
    tv.push_back('{0, 0, 1, pk(4'hA, 4'hF, 3'd1), 0, Z, 1, 0, 0, 0, 0, 0, Z, 5'd0});
    tv.push_back('{0, 0, 0, Z, 0, Z, 0, 0, 1, 0, 0, 1, pk(4'hA, 4'hF, 3'd1), 5'd0});
    tv.push_back('{0, 0, 0, Z, 0, Z, 0, 0, 0, 1, 0, 1, Z, f(4'hA, 4'hF, 3'd1)});
    tv.push_back('{0, 0, 0, Z, 0, Z, 0, 0, 0, 0, 0, 0, Z, 5'd0});
    // reset, then both valid: grants alternate 0,1,0,1
    tv.push_back('{1, 0, 0, Z, 0, Z, 0, 0, 0, 0, 0, 0, Z, 5'd0});
    tv.push_back('{0, 0, 1, pk(4'hF, 4'h0, 3'd7), 1, pk(4'h5, 4'h5, 3'd6), 1, 0, 0, 0, 0, 0, Z, 5'd0});
    tv.push_back('{0, 0, 1, pk(4'hF, 4'h1, 3'd7), 1, pk(4'h5, 4'h5, 3'd6), 0, 1, 1, 0, 0, 1, pk(4'hF, 4'h0, 3'd7), 5'd0});
    tv.push_back('{0, 0, 1, pk(4'hF, 4'h1, 3'd7), 1, pk(4'h5, 4'h5, 3'd6), 1, 0, 1, 1, 0, 1, pk(4'h5, 4'h5, 3'd6), f(4'hF, 4'h0, 3'd7)});
    tv.push_back('{0, 0, 1, pk(4'hF, 4'h2, 3'd7), 1, pk(4'h5, 4'h5, 3'd6), 0, 1, 1, 0, 1, 1, pk(4'hF, 4'h1, 3'd7), f(4'h5, 4'h5, 3'd6)});
    tv.push_back('{0, 0, 0, Z, 0, Z, 0, 0, 1, 1, 0, 1, pk(4'h5, 4'h5, 3'd6), f(4'hF, 4'h1, 3'd7)});
    tv.push_back('{0, 0, 0, Z, 0, Z, 0, 0, 0, 0, 1, 1, Z, f(4'h5, 4'h5, 3'd6)});
    tv.push_back('{0, 0, 0, Z, 0, Z, 0, 0, 0, 0, 0, 0, Z, 5'd0});
    // req1 alone three times, then both: pointer favours 0
    tv.push_back('{0, 0, 0, Z, 1, pk(4'h1, 4'h2, 3'd0), 0, 1, 0, 0, 0, 0, Z, 5'd0});
    tv.push_back('{0, 0, 0, Z, 1, pk(4'h3, 4'h4, 3'd0), 0, 1, 1, 0, 0, 1, pk(4'h1, 4'h2, 3'd0), 5'd0});
    tv.push_back('{0, 0, 0, Z, 1, pk(4'h5, 4'h6, 3'd0), 0, 1, 1, 0, 1, 1, pk(4'h3, 4'h4, 3'd0), f(4'h1, 4'h2, 3'd0)});
    tv.push_back('{0, 0, 1, pk(4'h7, 4'h8, 3'd2), 1, pk(4'h9, 4'hA, 3'd4), 1, 0, 1, 0, 1, 1, pk(4'h5, 4'h6, 3'd0), f(4'h3, 4'h4, 3'd0)});
    tv.push_back('{0, 0, 0, Z, 1, pk(4'h9, 4'hA, 3'd4), 0, 1, 1, 0, 1, 1, pk(4'h7, 4'h8, 3'd2), f(4'h5, 4'h6, 3'd0)});
    tv.push_back('{0, 0, 0, Z, 0, Z, 0, 0, 1, 1, 0, 1, pk(4'h9, 4'hA, 3'd4), f(4'h7, 4'h8, 3'd2)});
    tv.push_back('{0, 0, 0, Z, 0, Z, 0, 0, 0, 0, 1, 1, Z, f(4'h9, 4'hA, 3'd4)});
    tv.push_back('{0, 0, 0, Z, 0, Z, 0, 0, 0, 0, 0, 0, Z, 5'd0});
    // hold for three cycles mid-stream: in-flight ops still respond, pointer kept
    tv.push_back('{0, 0, 1, pk(4'h1, 4'h1, 3'd0), 1, pk(4'h2, 4'h2, 3'd0), 1, 0, 0, 0, 0, 0, Z, 5'd0});
    tv.push_back('{0, 0, 1, pk(4'h1, 4'h2, 3'd0), 1, pk(4'h2, 4'h2, 3'd0), 0, 1, 1, 0, 0, 1, pk(4'h1, 4'h1, 3'd0), 5'd0});
    tv.push_back('{0, 1, 1, pk(4'h1, 4'h2, 3'd0), 1, pk(4'h3, 4'h3, 3'd0), 0, 0, 1, 1, 0, 1, pk(4'h2, 4'h2, 3'd0), f(4'h1, 4'h1, 3'd0)});
    tv.push_back('{0, 1, 1, pk(4'h1, 4'h2, 3'd0), 1, pk(4'h3, 4'h3, 3'd0), 0, 0, 0, 0, 1, 1, Z, f(4'h2, 4'h2, 3'd0)});
    tv.push_back('{0, 1, 1, pk(4'h1, 4'h2, 3'd0), 1, pk(4'h3, 4'h3, 3'd0), 0, 0, 0, 0, 0, 0, Z, 5'd0});
    tv.push_back('{0, 0, 1, pk(4'h1, 4'h2, 3'd0), 1, pk(4'h3, 4'h3, 3'd0), 1, 0, 0, 0, 0, 0, Z, 5'd0});
    tv.push_back('{0, 0, 1, pk(4'h4, 4'h4, 3'd0), 1, pk(4'h3, 4'h3, 3'd0), 0, 1, 1, 0, 0, 1, pk(4'h1, 4'h2, 3'd0), 5'd0});
    tv.push_back('{0, 0, 0, Z, 0, Z, 0, 0, 1, 1, 0, 1, pk(4'h3, 4'h3, 3'd0), f(4'h1, 4'h2, 3'd0)});
    tv.push_back('{0, 0, 0, Z, 0, Z, 0, 0, 0, 0, 1, 1, Z, f(4'h3, 4'h3, 3'd0)});
    tv.push_back('{0, 0, 0, Z, 0, Z, 0, 0, 0, 0, 0, 0, Z, 5'd0});
    // reset with an op in flight: no response, outputs zero, req0 wins afterwards
    tv.push_back('{0, 0, 1, pk(4'h6, 4'h7, 3'd0), 0, Z, 1, 0, 0, 0, 0, 0, Z, 5'd0});
    tv.push_back('{1, 0, 1, pk(4'h8, 4'h1, 3'd0), 1, pk(4'h9, 4'h1, 3'd0), 0, 0, 0, 0, 0, 0, Z, 5'd0});
    tv.push_back('{0, 0, 1, pk(4'h8, 4'h1, 3'd0), 1, pk(4'h9, 4'h1, 3'd0), 1, 0, 0, 0, 0, 0, Z, 5'd0});
    tv.push_back('{0, 0, 0, Z, 0, Z, 0, 0, 1, 0, 0, 1, pk(4'h8, 4'h1, 3'd0), 5'd0});
    tv.push_back('{0, 0, 0, Z, 0, Z, 0, 0, 0, 1, 0, 1, Z, f(4'h8, 4'h1, 3'd0)});
    tv.push_back('{0, 0, 0, Z, 0, Z, 0, 0, 0, 0, 0, 0, Z, 5'd0});
    for (int k = 0; k < tv.size(); k++) begin
      @(posedge clk);
      #1;
      rst = tv[k].rst;
      hold = tv[k].hold;
      v0 = tv[k].v0;
      v1 = tv[k].v1;
      {a0, b0, op0} = tv[k].s0;
      {a1, b1, op1} = tv[k].s1;
      #1;
      chk($sformatf("ready0[%0d]", k), r0, tv[k].r0);
      chk($sformatf("ready1[%0d]", k), r1, tv[k].r1);
      chk($sformatf("alu_en[%0d]", k), en, tv[k].en);
      chk($sformatf("rsp0[%0d]", k), rv0, tv[k].rv0);
      chk($sformatf("rsp1[%0d]", k), rv1, tv[k].rv1);
      chk($sformatf("busy[%0d]", k), busy, tv[k].busy);
      if (tv[k].en || tv[k].rst) chk($sformatf("alu_bus[%0d]", k), {aa, ab, aop}, tv[k].bus);
      if (tv[k].rv0 || tv[k].rv1) chk($sformatf("rsp_data[%0d]", k), {carry, res}, tv[k].d);
    end
    // ALU_LAT=3: three back-to-back req0 ops respond in cycles 4,5,6 in order
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      v03 = c < 3;
      {a03, b03, op03} = {4'(c + 1), 4'hF, 3'd3};
      #1;
      chk($sformatf("lat3_ready0[%0d]", c), r03, c < 3);
      chk($sformatf("lat3_rsp0[%0d]", c), rv03, c >= 4 && c <= 6);
      chk($sformatf("lat3_rsp1[%0d]", c), rv13, 0);
      if (c >= 4 && c <= 6) chk($sformatf("lat3_data[%0d]", c), {carry3, res3}, f(4'(c - 3), 4'hF, 3'd3));
    end
    chk("lat3_busy_end", busy3, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Two-requester round-robin arbiter that time-shares the team's clocked 4-bit ALU (a, b, op -> result, carry). It accepts operand/op packets over valid/ready, drives the shared ALU input bus one issue per cycle and tracks in-flight ownership through the ALU latency. It routes each result/carry back to the requester that issued it. It sits between the two datapath clients and the single ALU instance.

Parameters:
DW, 4, operand/result width
OPW, 3, opcode width
ALU_LAT, 1, cycles from ALU input sampled to result valid (legal range 1..4)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
hold  in  1  when high, no new grants; in-flight ops complete
req0_valid  in  1  requester 0 packet valid
req0_ready  out  1  requester 0 packet accepted this cycle
req0_a / req0_b  in  DW  requester 0 operands
req0_op  in  OPW  requester 0 opcode
req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0
rsp0_valid  out  1  one-cycle pulse, result for requester 0
rsp1_valid  out  1  one-cycle pulse, result for requester 1
rsp_result  out  DW  shared response data, = alu_result
rsp_carry  out  1  shared response carry, = alu_carry
alu_a / alu_b  out  DW  registered ALU operands
alu_op  out  OPW  registered ALU opcode
alu_en  out  1  high in cycles carrying a newly issued op
alu_result  in  DW  from ALU
alu_carry  in  1  from ALU
busy  out  1  any op issued or in flight

Behaviour:
- Reset (async, rst=1): alu_a/alu_b/alu_op=0, alu_en=0, all tag stages cleared, rsp0/rsp1_valid=0, busy=0, last-grant pointer=1 (requester 0 wins first).
- Grant (combinational on the current cycle): hold=1 -> both readys 0. Otherwise one valid requester -> its ready=1. Both valid -> grant the one not last granted. At most one ready high per cycle; a ready is never high without its valid.
- Handshake at the edge where valid&ready: capture a/b/op into alu_a/b/op, set alu_en=1 for the next cycle, update last-grant pointer, push tag {valid=1, id} into the ALU_LAT-deep tag shift register.
- No grant: alu_en=0 next cycle; alu_a/b/op hold previous values, with no toggling.
- Requesters hold a/b/op stable while valid and not ready. The arbiter does not require this after acceptance.
- Latency: accepted at the edge ending cycle t -> alu_en in cycle t+1 -> rspN_valid in cycle t+1+ALU_LAT (ALU_LAT=1 gives t+2).
- rsp_result/rsp_carry pass through the ALU outputs combinationally. They are qualified only by rsp0_valid/rsp1_valid, which decode the tag at the last stage. Exactly one or zero rsp valids per cycle.
- Throughput: one issue per cycle, fully pipelined. With both requesters continuously valid and hold=0, grants strictly alternate.
- No response backpressure: requesters consume rsp pulses unconditionally.
- busy = alu_en OR any tag stage valid.
- hold asserted mid-stream: issued ops still respond on schedule. Deasserting hold resumes with the pointer unchanged.
- rst asserted with ops in flight: tags flush immediately and no rsp pulse is ever emitted for them. First grant after release goes to requester 0 if both are valid.
- Unused/illegal opcode values pass through unchanged; interpretation is the ALU's.

Test Plan:
- ALU_LAT=1, req0 only: a=1010, b=1111, op=001 accepted in cycle 0 -> alu_en=1 with alu_a=1010, alu_b=1111, alu_op=001 in cycle 1. rsp0_valid=1, rsp1_valid=0 in cycle 2, and rsp_result/rsp_carry equal the bench ALU model output.
- Both requesters valid for 4 consecutive cycles (req0 a=1111, b=0000+i, op=111; req1 a=0101, b=0101, op=110) -> grants 0,1,0,1. Responses alternate rsp0, rsp1 from cycle 2 with matching data. Exactly one ready per cycle.
- req1 valid alone for 3 cycles, then both valid -> grants 1,1,1, then 0 (pointer=1 favours 0). No idle cycles; busy stays 1 until the last rsp.
- hold=1 for cycles 2-4 during continuous dual requests -> ready low in cycles 2-4. Ops accepted in cycles 0-1 still respond in cycles 2-3. Granting resumes in cycle 5 with correct alternation.
- rst pulsed in cycle 1 after an accept in cycle 0 -> no rsp pulse ever for that op. All outputs are 0 during reset. After release with both valid, requester 0 is granted first.
- ALU_LAT=3, back-to-back req0 ops a=0001/0010/0011, b=1111, op=011 -> rsp0_valid in cycles 4, 5, 6 with results in issue order.
